// File: rtl/token_move_controller.sv
// token_move_controller
//   Sequences player-token movement along a 10-tile board (tiles 0..LAST_TILE).
//   The controller accepts a move request (player, dice value 1..6) from the game
//   FSM. It then advances that player's tile index by one tile every STEP_CYCLES
//   clocks, so each hop is visible on screen. It tracks both positions and
//   detects the winner. cur_tile_idx_o drives the shared tile->x,y mapper.
//
//   Optional feature macro: BOUNCE_BACK_EN
//     undefined : a hop that lands on LAST_TILE ends the move (overshoot clamps)
//     defined   : overshoot bounces back off LAST_TILE; a win needs an exact landing
//
// Ports
//   clk_i            system clock
//   rst_ni           synchronous active-low reset (overrides game_clear_i)
//   game_clear_i     synchronous clear of positions/winner, aborts any move
//   move_req_i       level request, sampled only while idle
//   move_player_i    requesting player (0/1)
//   move_steps_i     dice value, legal 1..6
//   move_ack_o       1-cycle pulse: request accepted
//   move_err_o       1-cycle pulse: request rejected (illegal steps or game over)
//   busy_o           move in progress
//   step_pulse_o     1-cycle pulse per tile hop
//   move_done_o      1-cycle pulse at end of move
//   cur_tile_idx_o   tile of the active (or last) mover, to the position mapper
//   p0_tile_o        player 0 tile index
//   p1_tile_o        player 1 tile index
//   game_over_o      sticky until reset/clear
//   winner_o         winning player, valid while game_over_o
module token_move_controller #(
    parameter int unsigned STEP_CYCLES = 25_000_000,
    parameter logic [3:0]  LAST_TILE   = 4'd9
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       game_clear_i,
    input  logic       move_req_i,
    input  logic       move_player_i,
    input  logic [2:0] move_steps_i,
    output logic       move_ack_o,
    output logic       move_err_o,
    output logic       busy_o,
    output logic       step_pulse_o,
    output logic       move_done_o,
    output logic [3:0] cur_tile_idx_o,
    output logic [3:0] p0_tile_o,
    output logic [3:0] p1_tile_o,
    output logic       game_over_o,
    output logic       winner_o
);

    localparam int unsigned       TimerW   = $clog2(STEP_CYCLES);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        remain_q, remain_d;
    logic              player_q, player_d;
    logic [3:0]        p0_q, p0_d, p1_q, p1_d, cur_q, cur_d;
    logic              ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic              step_q, step_d, done_q, done_d;
    logic              over_q, over_d, winner_q, winner_d;

    logic              steps_legal;
    logic [2:0]        remain_dec;
    logic [3:0]        hop_tile;
    logic              hop_end;

`ifdef BOUNCE_BACK_EN
    logic              fwd_q, fwd_d;
`endif

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        remain_d = remain_q;
        player_d = player_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        cur_d    = cur_q;
        busy_d   = busy_q;
        over_d   = over_q;
        winner_d = winner_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        step_d   = 1'b0;
        done_d   = 1'b0;

        steps_legal = (move_steps_i != 3'd0) && (move_steps_i != 3'd7);
        remain_dec  = remain_q - 3'd1;

        // cur_q always holds the active player's tile while a move is in flight.
`ifdef BOUNCE_BACK_EN
        fwd_d = fwd_q;
        if (fwd_q) begin
            hop_tile = (cur_q < LAST_TILE) ? cur_q + 4'd1 : cur_q;
        end else begin
            hop_tile = (cur_q != 4'd0) ? cur_q - 4'd1 : cur_q;
        end
        hop_end = (remain_dec == 3'd0);
`else
        hop_tile = (cur_q < LAST_TILE) ? cur_q + 4'd1 : cur_q;
        // Landing on the goal discards any remaining steps.
        hop_end  = (remain_dec == 3'd0) || (hop_tile == LAST_TILE);
`endif

        unique case (state_q)
            StIdle: begin
                if (move_req_i) begin
                    if (steps_legal && !over_q) begin
                        ack_d    = 1'b1;
                        busy_d   = 1'b1;
                        remain_d = move_steps_i;
                        timer_d  = '0;
                        player_d = move_player_i;
                        cur_d    = move_player_i ? p1_q : p0_q;
                        state_d  = StWait;
`ifdef BOUNCE_BACK_EN
                        fwd_d    = 1'b1;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (timer_q == TimerMax) begin
                    timer_d  = '0;
                    remain_d = remain_dec;
                    step_d   = 1'b1;
                    cur_d    = hop_tile;
                    if (player_q) begin
                        p1_d = hop_tile;
                    end else begin
                        p0_d = hop_tile;
                    end
`ifdef BOUNCE_BACK_EN
                    // Reaching the goal with steps left turns the token around.
                    if (fwd_q && (hop_tile == LAST_TILE) && (remain_dec != 3'd0)) begin
                        fwd_d = 1'b0;
                    end
`endif
                    if (hop_end) begin
                        state_d = StDone;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                if (cur_q == LAST_TILE) begin
                    over_d   = 1'b1;
                    winner_d = player_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || game_clear_i) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            remain_q <= '0;
            player_q <= 1'b0;
            p0_q     <= '0;
            p1_q     <= '0;
            cur_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
`ifdef BOUNCE_BACK_EN
            fwd_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            remain_q <= remain_d;
            player_q <= player_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            cur_q    <= cur_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            step_q   <= step_d;
            done_q   <= done_d;
            over_q   <= over_d;
            winner_q <= winner_d;
`ifdef BOUNCE_BACK_EN
            fwd_q    <= fwd_d;
`endif
        end
    end

    assign move_ack_o     = ack_q;
    assign move_err_o     = err_q;
    assign busy_o         = busy_q;
    assign step_pulse_o   = step_q;
    assign move_done_o    = done_q;
    assign cur_tile_idx_o = cur_q;
    assign p0_tile_o      = p0_q;
    assign p1_tile_o      = p1_q;
    assign game_over_o    = over_q;
    assign winner_o       = winner_q;

endmodule

// File: tb/tb_token_move_controller.sv
// tb_token_move_controller
//   Directed bench for token_move_controller with STEP_CYCLES = 4.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
//   Expected values for the overshoot move follow BOUNCE_BACK_EN when defined.
module tb_token_move_controller;

    localparam int unsigned StepCycles = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_clear = 1'b0;
    logic       move_req = 1'b0;
    logic       move_player = 1'b0;
    logic [2:0] move_steps = 3'd0;
    logic       move_ack, move_err, busy, step_pulse, move_done;
    logic [3:0] cur_tile_idx, p0_tile, p1_tile;
    logic       game_over, winner;

    int n_cmp = 0;
    int n_bad = 0;

    token_move_controller #(
        .STEP_CYCLES (StepCycles),
        .LAST_TILE   (4'd9)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .game_clear_i   (game_clear),
        .move_req_i     (move_req),
        .move_player_i  (move_player),
        .move_steps_i   (move_steps),
        .move_ack_o     (move_ack),
        .move_err_o     (move_err),
        .busy_o         (busy),
        .step_pulse_o   (step_pulse),
        .move_done_o    (move_done),
        .cur_tile_idx_o (cur_tile_idx),
        .p0_tile_o      (p0_tile),
        .p1_tile_o      (p1_tile),
        .game_over_o    (game_over),
        .winner_o       (winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"}, move_ack, 0);
        check_eq({tag, "_err"}, move_err, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_step"}, step_pulse, 0);
        check_eq({tag, "_done"}, move_done, 0);
        check_eq({tag, "_cur"}, cur_tile_idx, 0);
        check_eq({tag, "_p0"}, p0_tile, 0);
        check_eq({tag, "_p1"}, p1_tile, 0);
        check_eq({tag, "_over"}, game_over, 0);
        check_eq({tag, "_winner"}, winner, 0);
    endtask

    // Issue a request, then follow the move to move_done within a cycle budget.
    // Hop timing and each hop's tile come from a small board model.
    task automatic run_move(input logic pl, input logic [2:0] steps, input logic [3:0] start,
                            input int exp_hops, input logic [3:0] exp_final,
                            input logic exp_over, input logic poke);
        int         hops;
        int         cyc;
        logic       got_done;
        logic [3:0] tile;
        logic       fwd;
        logic [2:0] rem;
        hops = 0; cyc = 0; got_done = 1'b0; tile = start; fwd = 1'b1; rem = steps;
        move_req = 1'b1; move_player = pl; move_steps = steps;
        tick();
        move_req = 1'b0;
        check_eq("accept_ack", move_ack, 1);
        check_eq("accept_busy", busy, 1);
        check_eq("accept_cur", cur_tile_idx, start);
        while (!got_done && cyc < 100) begin
            if (poke && cyc == 5) begin
                move_req = 1'b1; move_player = ~pl; move_steps = 3'd2;
            end
            tick();
            cyc++;
            if (poke && cyc == 6) begin
                move_req = 1'b0;
                check_eq("busy_req_ack", move_ack, 0);
                check_eq("busy_req_err", move_err, 0);
            end
            if (step_pulse) begin
                hops++;
`ifdef BOUNCE_BACK_EN
                tile = fwd ? tile + 4'd1 : tile - 4'd1;
                rem  = rem - 3'd1;
                if (tile == 4'd9 && rem != 3'd0) fwd = 1'b0;
`else
                tile = tile + 4'd1;
`endif
                check_eq("hop_time", cyc, hops * StepCycles);
                check_eq("hop_tile", cur_tile_idx, tile);
            end
            if (move_done) begin
                got_done = 1'b1;
                check_eq("done_time", cyc, hops * StepCycles + 1);
            end
        end
        check_eq("done_seen", got_done, 1);
        check_eq("hop_count", hops, exp_hops);
        check_eq("final_tile", pl ? p1_tile : p0_tile, exp_final);
        check_eq("end_busy", busy, 0);
        check_eq("end_over", game_over, exp_over);
        tick();
        check_eq("done_pulse_low", move_done, 0);
    endtask

    initial begin
        logic seen_done;

        // Reset
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Test 1: p0 moves 3 with exact pulse timing
        run_move(1'b0, 3'd3, 4'd0, 3, 4'd3, 1'b0, 1'b0);
        check_eq("t1_p1", p1_tile, 0);

        // Test 2: illegal dice values
        move_req = 1'b1; move_player = 1'b1; move_steps = 3'd0;
        tick();
        check_eq("t2_err0", move_err, 1);
        check_eq("t2_ack0", move_ack, 0);
        move_steps = 3'd7;
        tick();
        check_eq("t2_err7", move_err, 1);
        check_eq("t2_ack7", move_ack, 0);
        move_req = 1'b0;
        tick();
        check_eq("t2_err_low", move_err, 0);
        check_eq("t2_busy", busy, 0);
        check_eq("t2_p1", p1_tile, 0);

        // Test 4: p1 to 3, then 6 to the goal with an ignored p0 request mid-move
        run_move(1'b1, 3'd3, 4'd0, 3, 4'd3, 1'b0, 1'b0);
        run_move(1'b1, 3'd6, 4'd3, 6, 4'd9, 1'b1, 1'b1);
        check_eq("t4_winner", winner, 1);
        check_eq("t4_p0", p0_tile, 3);

        // Test 6a: request after game over is rejected, positions frozen
        move_req = 1'b1; move_player = 1'b0; move_steps = 3'd2;
        tick();
        move_req = 1'b0;
        check_eq("t6_err", move_err, 1);
        check_eq("t6_ack", move_ack, 0);
        repeat (6) tick();
        check_eq("t6_p0", p0_tile, 3);
        check_eq("t6_p1", p1_tile, 9);
        check_eq("t6_over", game_over, 1);

        // game_clear restores the start state
        game_clear = 1'b1;
        tick();
        game_clear = 1'b0;
        check_all_zero("clear");

        // Test 3: p0 to 7, then 4 overshoots the goal
        run_move(1'b0, 3'd6, 4'd0, 6, 4'd6, 1'b0, 1'b0);
        run_move(1'b0, 3'd1, 4'd6, 1, 4'd7, 1'b0, 1'b0);
`ifdef BOUNCE_BACK_EN
        run_move(1'b0, 3'd4, 4'd7, 4, 4'd7, 1'b0, 1'b0);
`else
        run_move(1'b0, 3'd4, 4'd7, 2, 4'd9, 1'b1, 1'b0);
        check_eq("t3_winner", winner, 0);
`endif
        check_eq("t3_p1", p1_tile, 0);
        game_clear = 1'b1;
        tick();
        game_clear = 1'b0;

        // Test 5: clear during hop 2 aborts the move without move_done
        move_req = 1'b1; move_player = 1'b0; move_steps = 3'd3;
        tick();
        move_req = 1'b0;
        check_eq("t5_ack", move_ack, 1);
        repeat (4) tick();
        check_eq("t5_hop1", p0_tile, 1);
        repeat (2) tick();
        game_clear = 1'b1;
        tick();
        game_clear = 1'b0;
        check_eq("t5_p0", p0_tile, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_cur", cur_tile_idx, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (move_done || step_pulse) seen_done = 1'b1;
        end
        check_eq("t5_no_done", seen_done, 0);
        run_move(1'b1, 3'd1, 4'd0, 1, 4'd1, 1'b0, 1'b0);

        // Test 6b: reset in the middle of a move wins over game_clear
        move_req = 1'b1; move_player = 1'b0; move_steps = 3'd2;
        tick();
        move_req = 1'b0;
        check_eq("t6_ack2", move_ack, 1);
        repeat (5) tick();
        check_eq("t6_midmove_p0", p0_tile, 1);
        rst_n = 1'b0;
        game_clear = 1'b1;
        tick();
        rst_n = 1'b1;
        game_clear = 1'b0;
        check_all_zero("midreset");
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (move_done || step_pulse) seen_done = 1'b1;
        end
        check_eq("t6_no_done", seen_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
